board_vga_renderer: RTL and testbench

//  Display stage directly downstream of the Game of Life top: consumes the 256-bit board (16x16 cells)
//  and drives a 640x480@60Hz VGA port (12-bit RGB). Generates sync timing from the system clock via
//  a pixel-enable divider. Snapshots the board once per frame at vblank start, so a frame never tears.

---
 rtl/board_vga_renderer.sv | 149 ++++++++++++++
 tb/tb_board_vga_renderer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_vga_renderer.sv
// board_vga_renderer
//   Renders a 16x16 Game of Life board onto a 640x480@60Hz VGA port.
//   A pixel-enable divider derives the pixel rate from clk. The board is
//   snapshotted once per frame at the start of vertical blanking, so a
//   frame never shows a mix of two boards.
// Ports
//   clk           system clock
//   reset         asynchronous, active-high reset
//   board_i       live board, bit [row*16+col] = 1 means alive
//   vga_hsync_o   horizontal sync, active low
//   vga_vsync_o   vertical sync, active low
//   vga_r_o/g/b   4-bit colour channels
//   frame_start_o one-clk pulse on the edge that loads the board snapshot
module board_vga_renderer #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CELL_SHIFT = 4,
  parameter int unsigned BOARD_X0   = 192,
  parameter int unsigned BOARD_Y0   = 112,
  parameter logic [11:0] ALIVE_RGB  = 12'hFFF,
  parameter logic [11:0] DEAD_RGB   = 12'h222,
  parameter logic [11:0] GRID_RGB   = 12'h444,
  parameter logic [11:0] BG_RGB     = 12'h000,
  parameter bit          GRID_EN    = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] board_i,
  output logic         vga_hsync_o,
  output logic         vga_vsync_o,
  output logic [3:0]   vga_r_o,
  output logic [3:0]   vga_g_o,
  output logic [3:0]   vga_b_o,
  output logic         frame_start_o
);

  localparam int unsigned CNT_W        = 10;
  localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam int unsigned H_VISIBLE    = 640;
  localparam int unsigned H_SYNC_START = 656;
  localparam int unsigned H_SYNC_END   = 752;
  localparam int unsigned H_TOTAL      = 800;
  localparam int unsigned V_VISIBLE    = 480;
  localparam int unsigned V_SYNC_START = 490;
  localparam int unsigned V_SYNC_END   = 492;
  localparam int unsigned V_TOTAL      = 525;

  localparam int unsigned BOARD_PX     = 16 << CELL_SHIFT;
  localparam int unsigned BOARD_X1     = BOARD_X0 + BOARD_PX;
  localparam int unsigned BOARD_Y1     = BOARD_Y0 + BOARD_PX;
  localparam int unsigned CELL_MASK    = (1 << CELL_SHIFT) - 1;

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [255:0]     snapshot;

  logic             pix_tick;
  logic             h_last;
  logic             v_last;
  logic             snap_point;
  logic             hsync_c;
  logic             vsync_c;
  logic             visible;
  logic             in_board;
  logic             on_grid;
  logic [CNT_W-1:0] dx;
  logic [CNT_W-1:0] dy;
  logic [7:0]       cell_idx;
  logic [11:0]      rgb_c;

  // Pixel-rate enable and counter boundaries
  always_comb begin
    pix_tick   = (div_cnt == DIV_W'(CLK_DIV - 1));
    h_last     = (h_cnt == CNT_W'(H_TOTAL - 1));
    v_last     = (v_cnt == CNT_W'(V_TOTAL - 1));
    snap_point = h_last && (v_cnt == CNT_W'(V_VISIBLE - 1));
  end

  // Sync and colour decode of the current (pre-increment) counter position
  always_comb begin
    hsync_c  = !((h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt < CNT_W'(H_SYNC_END)));
    vsync_c  = !((v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt < CNT_W'(V_SYNC_END)));
    visible  = (h_cnt < CNT_W'(H_VISIBLE)) && (v_cnt < CNT_W'(V_VISIBLE));
    in_board = (h_cnt >= CNT_W'(BOARD_X0)) && (h_cnt < CNT_W'(BOARD_X1)) &&
               (v_cnt >= CNT_W'(BOARD_Y0)) && (v_cnt < CNT_W'(BOARD_Y1));

    // Offsets only meaningful inside the window; zero elsewhere keeps them from wrapping
    dx = '0;
    dy = '0;
    if (in_board) begin
      dx = h_cnt - CNT_W'(BOARD_X0);
      dy = v_cnt - CNT_W'(BOARD_Y0);
    end

    on_grid  = GRID_EN && (((dx & CNT_W'(CELL_MASK)) == '0) ||
                           ((dy & CNT_W'(CELL_MASK)) == '0));
    cell_idx = {4'(dy >> CELL_SHIFT), 4'(dx >> CELL_SHIFT)};

    rgb_c = 12'h000;
    if (visible) begin
      if (!in_board) begin
        rgb_c = BG_RGB;
      end else if (on_grid) begin
        rgb_c = GRID_RGB;
      end else if (snapshot[cell_idx]) begin
        rgb_c = ALIVE_RGB;
      end else begin
        rgb_c = DEAD_RGB;
      end
    end
  end

  // Divider, raster counters, snapshot and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt       <= '0;
      h_cnt         <= '0;
      v_cnt         <= '0;
      snapshot      <= '0;
      vga_hsync_o   <= 1'b1;
      vga_vsync_o   <= 1'b1;
      vga_r_o       <= '0;
      vga_g_o       <= '0;
      vga_b_o       <= '0;
      frame_start_o <= 1'b0;
    end else begin
      div_cnt       <= pix_tick ? '0 : div_cnt + DIV_W'(1);
      frame_start_o <= pix_tick && snap_point;
      if (pix_tick) begin
        vga_hsync_o <= hsync_c;
        vga_vsync_o <= vsync_c;
        vga_r_o     <= rgb_c[11:8];
        vga_g_o     <= rgb_c[7:4];
        vga_b_o     <= rgb_c[3:0];
        if (snap_point) begin
          snapshot <= board_i;
        end
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
        end else begin
          h_cnt <= h_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_board_vga_renderer.sv
// tb_board_vga_renderer
//   Directed bench for board_vga_renderer. Three instances share clock,
//   reset and board: u_a (no grid), u_b (grid, default colours) and
//   u_c (grid, red background). Pixel (x,y) of frame f is loaded on clk
//   edge (f*420000 + y*800 + x + 1)*D counted from reset release.
module tb_board_vga_renderer;

  localparam int D         = 2;
  localparam int FRAME_PIX = 420000;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] board;

  logic       a_hs, a_vs, a_fs, b_hs, b_vs, b_fs, c_hs, c_vs, c_fs;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
  logic [11:0] a_rgb, b_rgb, c_rgb;

  int cyc;
  int fs_count;
  int errors = 0;
  int checks = 0;

  assign a_rgb = {a_r, a_g, a_b};
  assign b_rgb = {b_r, b_g, b_b};
  assign c_rgb = {c_r, c_g, c_b};

  board_vga_renderer #(.CLK_DIV(D), .GRID_EN(1'b0)) u_a (
    .clk(clk), .reset(rst), .board_i(board),
    .vga_hsync_o(a_hs), .vga_vsync_o(a_vs),
    .vga_r_o(a_r), .vga_g_o(a_g), .vga_b_o(a_b), .frame_start_o(a_fs));

  board_vga_renderer #(.CLK_DIV(D)) u_b (
    .clk(clk), .reset(rst), .board_i(board),
    .vga_hsync_o(b_hs), .vga_vsync_o(b_vs),
    .vga_r_o(b_r), .vga_g_o(b_g), .vga_b_o(b_b), .frame_start_o(b_fs));

  board_vga_renderer #(.CLK_DIV(D), .BG_RGB(12'hF00)) u_c (
    .clk(clk), .reset(rst), .board_i(board),
    .vga_hsync_o(c_hs), .vga_vsync_o(c_vs),
    .vga_r_o(c_r), .vga_g_o(c_g), .vga_b_o(c_b), .frame_start_o(c_fs));

  always #5 clk = ~clk;

  // Clock edges since reset release
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk or posedge rst) begin
    if (rst)       fs_count <= 0;
    else if (a_fs) fs_count <= fs_count + 1;
  end

  function automatic int pix_edge(input int f, input int x, input int y);
    return (f * FRAME_PIX + y * 800 + x + 1) * D;
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    board = '0;
    board[0]   = 1'b1;
    board[255] = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", a_hs); end
    checks++; if (a_vs !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", a_vs); end
    checks++; if (a_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb: got %h want 000", a_rgb); end
    checks++; if (a_fs !== 1'b0) begin errors++; $display("FAIL reset_fs: got %b want 0", a_fs); end
    checks++; if (c_rgb !== 12'h000) begin errors++; $display("FAIL reset_rgb_c: got %h want 000", c_rgb); end
    rst = 1'b0;
  endtask

  task automatic test_hsync_timing(input string tag);
    wait_cyc(657 * D - 1);
    checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL %s_hs_before: got %b want 1", tag, a_hs); end
    wait_cyc(657 * D);
    checks++; if (a_hs !== 1'b0) begin errors++; $display("FAIL %s_hs_fall: got %b want 0", tag, a_hs); end
    wait_cyc(753 * D - 1);
    checks++; if (a_hs !== 1'b0) begin errors++; $display("FAIL %s_hs_last_low: got %b want 0", tag, a_hs); end
    wait_cyc(753 * D);
    checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL %s_hs_rise: got %b want 1", tag, a_hs); end
    wait_cyc(1457 * D - 1);
    checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL %s_hs_line2_before: got %b want 1", tag, a_hs); end
    wait_cyc(1457 * D);
    checks++; if (a_hs !== 1'b0) begin errors++; $display("FAIL %s_hs_line2_fall: got %b want 0", tag, a_hs); end
  endtask

  task automatic test_first_frame_dead(input string tag);
    wait_cyc(pix_edge(0, 193, 113));
    checks++; if (b_rgb !== 12'h222) begin errors++; $display("FAIL %s_b_cell0: got %h want 222", tag, b_rgb); end
    wait_cyc(pix_edge(0, 200, 120));
    checks++; if (a_rgb !== 12'h222) begin errors++; $display("FAIL %s_a_cell0: got %h want 222", tag, a_rgb); end
  endtask

  task automatic test_blanking_bg;
    wait_cyc(pix_edge(0, 440, 360));
    checks++; if (a_rgb !== 12'h222) begin errors++; $display("FAIL dead_cell255: got %h want 222", a_rgb); end
    wait_cyc(pix_edge(0, 100, 400));
    checks++; if (a_rgb !== 12'h000) begin errors++; $display("FAIL bg_default: got %h want 000", a_rgb); end
    wait_cyc(pix_edge(0, 639, 400));
    checks++; if (c_rgb !== 12'hF00) begin errors++; $display("FAIL bg_x639: got %h want F00", c_rgb); end
    wait_cyc(pix_edge(0, 640, 400));
    checks++; if (c_rgb !== 12'h000) begin errors++; $display("FAIL hblank_x640: got %h want 000", c_rgb); end
    wait_cyc(pix_edge(0, 799, 400));
    checks++; if (c_rgb !== 12'h000) begin errors++; $display("FAIL hblank_x799: got %h want 000", c_rgb); end
    wait_cyc(pix_edge(0, 639, 479));
    checks++; if (c_rgb !== 12'hF00) begin errors++; $display("FAIL bg_y479: got %h want F00", c_rgb); end
  endtask

  task automatic test_frame_start(input int f, input int want_count);
    int t;
    t = pix_edge(f, 799, 479);
    wait_cyc(t - 1);
    checks++; if (a_fs !== 1'b0) begin errors++; $display("FAIL fs%0d_before: got %b want 0", f, a_fs); end
    checks++; if (fs_count !== want_count - 1) begin errors++; $display("FAIL fs%0d_count_before: got %0d want %0d", f, fs_count, want_count - 1); end
    wait_cyc(t);
    checks++; if (a_fs !== 1'b1) begin errors++; $display("FAIL fs%0d_pulse: got %b want 1", f, a_fs); end
    wait_cyc(t + 1);
    checks++; if (a_fs !== 1'b0) begin errors++; $display("FAIL fs%0d_after: got %b want 0", f, a_fs); end
  endtask

  task automatic test_vsync_vblank;
    wait_cyc(pix_edge(0, 100, 480));
    checks++; if (c_rgb !== 12'h000) begin errors++; $display("FAIL vblank_y480: got %h want 000", c_rgb); end
    wait_cyc(pix_edge(0, 0, 490) - 1);
    checks++; if (a_vs !== 1'b1) begin errors++; $display("FAIL vs_before: got %b want 1", a_vs); end
    wait_cyc(pix_edge(0, 0, 490));
    checks++; if (a_vs !== 1'b0) begin errors++; $display("FAIL vs_fall: got %b want 0", a_vs); end
    wait_cyc(pix_edge(0, 0, 492) - 1);
    checks++; if (a_vs !== 1'b0) begin errors++; $display("FAIL vs_last_low: got %b want 0", a_vs); end
    wait_cyc(pix_edge(0, 0, 492));
    checks++; if (a_vs !== 1'b1) begin errors++; $display("FAIL vs_rise: got %b want 1", a_vs); end
    wait_cyc(pix_edge(0, 100, 524));
    checks++; if (c_rgb !== 12'h000) begin errors++; $display("FAIL vblank_y524: got %h want 000", c_rgb); end
  endtask

  task automatic test_nogrid_cell;
    wait_cyc(pix_edge(1, 10, 0));
    checks++; if (fs_count !== 1) begin errors++; $display("FAIL fs_count_frame1: got %0d want 1", fs_count); end
    wait_cyc(pix_edge(1, 191, 112));
    checks++; if (a_rgb !== 12'h000) begin errors++; $display("FAIL nogrid_x191: got %h want 000", a_rgb); end
    wait_cyc(pix_edge(1, 192, 112));
    checks++; if (a_rgb !== 12'hFFF) begin errors++; $display("FAIL nogrid_x192: got %h want FFF", a_rgb); end
    checks++; if (b_rgb !== 12'h444) begin errors++; $display("FAIL grid_corner0: got %h want 444", b_rgb); end
    wait_cyc(pix_edge(1, 208, 112));
    checks++; if (a_rgb !== 12'h222) begin errors++; $display("FAIL nogrid_x208: got %h want 222", a_rgb); end
    wait_cyc(pix_edge(1, 193, 113));
    checks++; if (b_rgb !== 12'hFFF) begin errors++; $display("FAIL grid_cell0_inner: got %h want FFF", b_rgb); end
    wait_cyc(pix_edge(1, 207, 127));
    checks++; if (a_rgb !== 12'hFFF) begin errors++; $display("FAIL nogrid_x207y127: got %h want FFF", a_rgb); end
  endtask

  task automatic test_board_toggle;
    wait_cyc(pix_edge(1, 0, 200));
    board = '0;
    board[1] = 1'b1;
  endtask

  task automatic test_grid_cell;
    wait_cyc(pix_edge(1, 440, 352));
    checks++; if (b_rgb !== 12'h444) begin errors++; $display("FAIL grid_y352: got %h want 444", b_rgb); end
    wait_cyc(pix_edge(1, 433, 353));
    checks++; if (b_rgb !== 12'hFFF) begin errors++; $display("FAIL grid_x433y353: got %h want FFF", b_rgb); end
    wait_cyc(pix_edge(1, 432, 360));
    checks++; if (b_rgb !== 12'h444) begin errors++; $display("FAIL grid_x432: got %h want 444", b_rgb); end
    wait_cyc(pix_edge(1, 440, 360));
    checks++; if (a_rgb !== 12'hFFF) begin errors++; $display("FAIL toggle_same_frame: got %h want FFF", a_rgb); end
    wait_cyc(pix_edge(1, 448, 360));
    checks++; if (b_rgb !== 12'h000) begin errors++; $display("FAIL grid_x448_bg: got %h want 000", b_rgb); end
    wait_cyc(pix_edge(1, 447, 367));
    checks++; if (b_rgb !== 12'hFFF) begin errors++; $display("FAIL grid_x447y367: got %h want FFF", b_rgb); end
  endtask

  task automatic test_next_frame;
    wait_cyc(pix_edge(2, 200, 120));
    checks++; if (fs_count !== 2) begin errors++; $display("FAIL fs_count_frame2: got %0d want 2", fs_count); end
    checks++; if (a_rgb !== 12'h222) begin errors++; $display("FAIL newframe_cell0: got %h want 222", a_rgb); end
    wait_cyc(pix_edge(2, 209, 120));
    checks++; if (b_rgb !== 12'hFFF) begin errors++; $display("FAIL newframe_b_cell1: got %h want FFF", b_rgb); end
    wait_cyc(pix_edge(2, 210, 120));
    checks++; if (a_rgb !== 12'hFFF) begin errors++; $display("FAIL newframe_cell1: got %h want FFF", a_rgb); end
  endtask

  task automatic test_mid_frame_reset;
    board = '0;
    board[0] = 1'b1;
    wait_cyc(pix_edge(2, 400, 300));
    checks++; if (a_rgb !== 12'h222) begin errors++; $display("FAIL prereset_rgb: got %h want 222", a_rgb); end
    #2 rst = 1'b1;
    #1;
    checks++; if (a_hs !== 1'b1) begin errors++; $display("FAIL midreset_hsync: got %b want 1", a_hs); end
    checks++; if (a_vs !== 1'b1) begin errors++; $display("FAIL midreset_vsync: got %b want 1", a_vs); end
    checks++; if (a_rgb !== 12'h000) begin errors++; $display("FAIL midreset_rgb: got %h want 000", a_rgb); end
    checks++; if (b_rgb !== 12'h000) begin errors++; $display("FAIL midreset_rgb_b: got %h want 000", b_rgb); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_hsync_timing("rst2");
    test_first_frame_dead("rst2");
  endtask

  initial begin
    test_reset();
    test_hsync_timing("rst1");
    test_first_frame_dead("first");
    test_blanking_bg();
    test_frame_start(0, 1);
    test_vsync_vblank();
    test_nogrid_cell();
    test_board_toggle();
    test_grid_cell();
    test_frame_start(1, 2);
    test_next_frame();
    test_mid_frame_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
